// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states, address type
// and the alignment mask used by the misaligned-branch check.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef logic [31:0] addr_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_sequencer_pc_reg.sv
// 32-bit program-counter register with load enable.
// Asynchronous active-low reset loads RESET_VECTOR.
module pc_reg
  import pc_seq_pkg::*;
#(
  parameter addr_t RESET_VECTOR = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  addr_t d_in,
  output addr_t q_out
);

  // PC storage: only loads when the sequencer enables it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_out <= RESET_VECTOR;
    end else if (en) begin
      q_out <= d_in;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: chooses the next PC (trap > branch > increment),
// offers the PC to fetch with a valid/ready handshake and supports halt/resume.
// Optional build macro PC_MISALIGN_TRAP_EN: a misaligned branch target in RUN
// is replaced by TRAP_VECTOR and raises the sticky misalign_err flag.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter addr_t RESET_VECTOR = 32'h0000_0000,
  parameter addr_t TRAP_VECTOR  = 32'h0000_0100,
  parameter addr_t PC_INC       = 32'd4
) (
  input  logic  clk,
  input  logic  reset,
  output logic  fetch_valid,
  input  logic  fetch_ready,
  output addr_t pc_out,
  input  logic  branch_valid,
  input  addr_t branch_target,
  input  logic  trap_req,
  input  logic  halt_req,
  output logic  halted,
  output logic  misalign_err
);

  state_t state_q;
  state_t state_d;
  addr_t  pc_d;
  logic   pc_en;
  logic   redirect;
`ifdef PC_MISALIGN_TRAP_EN
  logic   mis_set;
`endif

  assign fetch_valid = (state_q == RUN);
  assign halted      = (state_q == HALT);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-PC selection; the PC is only written through pc_en
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_out;
    pc_en    = 1'b0;
    redirect = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    mis_set  = 1'b0;
`endif
    case (state_q)
      BOOT: begin
        // One idle cycle after reset; all requests are ignored here.
        state_d = RUN;
      end
      RUN: begin
        if (trap_req) begin
          redirect = 1'b1;
          pc_en    = 1'b1;
          pc_d     = TRAP_VECTOR;
        end else if (branch_valid) begin
          redirect = 1'b1;
          pc_en    = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
          if ((branch_target[1:0] & ALIGN_MASK) != 2'b00) begin
            pc_d    = TRAP_VECTOR;
            mis_set = 1'b1;
          end else begin
            pc_d = branch_target;
          end
`else
          pc_d = branch_target;
`endif
        end else if (fetch_ready) begin
          // fetch_valid is 1 in RUN, so ready alone completes the handshake.
          pc_en = 1'b1;
          pc_d  = pc_out + PC_INC;
        end
        // Halt only once the current offer is consumed (accepted or flushed).
        if (halt_req && (fetch_ready || redirect)) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (trap_req) begin
          pc_en   = 1'b1;
          pc_d    = TRAP_VECTOR;
          state_d = RUN;
        end else if (!halt_req) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk  (clk),
    .reset(reset),
    .en   (pc_en),
    .d_in (pc_d),
    .q_out(pc_out)
  );

`ifdef PC_MISALIGN_TRAP_EN
  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_err <= 1'b0;
    end else if (mis_set) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer. Each vector holds the inputs
// for one clock edge and the outputs expected just after that edge.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] pc_out;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        trap_req;
  logic        halt_req;
  logic        halted;
  logic        misalign_err;

  int n_vec;
  int n_bad;

  typedef struct {
    logic        rdy;
    logic        bv;
    logic [31:0] bt;
    logic        trap;
    logic        halt;
    logic        efv;
    logic [31:0] epc;
    logic        eh;
    logic        ee;
  } vec_t;

  vec_t vq[$];

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_PC = 32'h0000_0100;
  localparam logic        MIS_E  = 1'b1;
`else
  localparam logic [31:0] MIS_PC = 32'h0000_1002;
  localparam logic        MIS_E  = 1'b0;
`endif

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .pc_out       (pc_out),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .trap_req     (trap_req),
    .halt_req     (halt_req),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rdy, input logic bv, input logic [31:0] bt,
                     input logic trap, input logic halt, input logic efv,
                     input logic [31:0] epc, input logic eh, input logic ee);
    vec_t v;
    v.rdy = rdy; v.bv = bv; v.bt = bt; v.trap = trap; v.halt = halt;
    v.efv = efv; v.epc = epc; v.eh = eh; v.ee = ee;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic efv, input logic [31:0] epc,
                       input logic eh, input logic ee);
    n_vec++;
    if (fetch_valid !== efv || pc_out !== epc || halted !== eh || misalign_err !== ee) begin
      n_bad++;
      $display("FAIL %s: got fv=%0b pc=%h halted=%0b err=%0b, want fv=%0b pc=%h halted=%0b err=%0b",
               name, fetch_valid, pc_out, halted, misalign_err, efv, epc, eh, ee);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    fetch_ready = 1'b0;
    branch_valid = 1'b0;
    branch_target = 32'h0;
    trap_req = 1'b0;
    halt_req = 1'b0;

    //   rdy bv  target         trp hlt   fv  pc             h   err
    add(1, 0, 32'h0,          1, 0,   1, 32'h0000_0000, 0, 0);     // BOOT ignores trap
    add(1, 0, 32'h0,          0, 0,   1, 32'h0000_0004, 0, 0);
    add(1, 0, 32'h0,          0, 0,   1, 32'h0000_0008, 0, 0);
    add(0, 0, 32'h0,          0, 0,   1, 32'h0000_0008, 0, 0);     // stall x3
    add(0, 0, 32'h0,          0, 0,   1, 32'h0000_0008, 0, 0);
    add(0, 0, 32'h0,          0, 0,   1, 32'h0000_0008, 0, 0);
    add(1, 0, 32'h0,          0, 0,   1, 32'h0000_000C, 0, 0);
    add(1, 0, 32'h0,          0, 0,   1, 32'h0000_0010, 0, 0);
    add(1, 1, 32'h2000,       1, 0,   1, 32'h0000_0100, 0, 0);     // trap beats branch
    add(1, 1, 32'h2000,       0, 0,   1, 32'h0000_2000, 0, 0);     // branch beats handshake
    add(0, 1, 32'h3000,       0, 0,   1, 32'h0000_3000, 0, 0);     // branch during stall
    add(0, 1, 32'h20,         0, 0,   1, 32'h0000_0020, 0, 0);
    add(0, 0, 32'h0,          0, 1,   1, 32'h0000_0020, 0, 0);     // halt waits for accept
    add(1, 0, 32'h0,          0, 1,   0, 32'h0000_0024, 1, 0);     // halt on handshake
    add(1, 0, 32'h0,          0, 1,   0, 32'h0000_0024, 1, 0);
    add(0, 1, 32'h5000,       0, 1,   0, 32'h0000_0024, 1, 0);     // branch ignored in HALT
    add(0, 0, 32'h0,          0, 0,   1, 32'h0000_0024, 0, 0);     // resume same PC
    add(0, 1, 32'h30,         0, 1,   0, 32'h0000_0030, 1, 0);     // halt on redirect
    add(0, 0, 32'h0,          1, 1,   1, 32'h0000_0100, 0, 0);     // trap leaves HALT
    add(1, 0, 32'h0,          0, 1,   0, 32'h0000_0104, 1, 0);     // re-halt on handshake
    add(0, 0, 32'h0,          0, 0,   1, 32'h0000_0104, 0, 0);
    add(0, 1, 32'hFFFF_FFFC,  0, 0,   1, 32'hFFFF_FFFC, 0, 0);
    add(1, 0, 32'h0,          0, 0,   1, 32'h0000_0000, 0, 0);     // wrap
    add(1, 1, 32'h1002,       0, 0,   1, MIS_PC,        0, MIS_E); // misaligned target
    add(1, 0, 32'h0,          0, 0,   1, MIS_PC + 32'd4, 0, MIS_E);
    add(0, 1, 32'h40,         0, 0,   1, 32'h0000_0040, 0, MIS_E);
    add(0, 0, 32'h0,          0, 0,   1, 32'h0000_0040, 0, MIS_E);

    @(negedge clk);
    @(negedge clk);
    check("reset_values", 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      fetch_ready   = vq[i].rdy;
      branch_valid  = vq[i].bv;
      branch_target = vq[i].bt;
      trap_req      = vq[i].trap;
      halt_req      = vq[i].halt;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vq[i].efv, vq[i].epc, vq[i].eh, vq[i].ee);
      @(negedge clk);
    end

    // Asynchronous reset mid-stall at 0x40
    fetch_ready = 1'b0;
    branch_valid = 1'b0;
    trap_req = 1'b0;
    halt_req = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("async_reset", 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    fetch_ready = 1'b1;
    #1;
    check("boot_after_reset", 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("run_after_boot", 1'b1, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("incr_after_reset", 1'b1, 32'h4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
